imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_inst_assembler.sv | 45 ++++
 rtl/imem_loader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared loader constants, state encoding.
// CHK exists only with LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int INST_WIDTH     = 41;
  localparam int BYTES_PER_INST = 6;
  localparam int IMEM_DEPTH     = 1024;
  localparam int IMEM_ADDR_W    = $clog2(IMEM_DEPTH);
  localparam int CNT_W          = 3;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    COLLECT,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } loaderState_e;

endpackage

// File: rtl/imem_loader_inst_assembler.sv
// inst_assembler: packs 6 LSB-first bytes into one word.
// Ports: clk, rst, clear, byteValid, byteIn -> word, full.
module inst_assembler
  import imem_loader_pkg::*;
#(
  parameter int INST_W = INST_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byteValid,
  input  logic [7:0]        byteIn,
  output logic [INST_W-1:0] word,
  output logic              full
);

  localparam int LO_W  = 8 * (BYTES_PER_INST - 1);
  localparam int TOP_W = INST_W - LO_W;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(BYTES_PER_INST - 1);

  logic [CNT_W-1:0] cnt;
  logic             lastByte;

  assign lastByte = (cnt == LAST);
  // High when this accepted byte completes a word.
  assign full = byteValid && lastByte;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt  <= '0;
      word <= '0;
    end else if (byteValid) begin
      if (lastByte) begin
        cnt <= '0;
        // Only the low bits of the top byte survive.
        word[INST_W-1 -: TOP_W] <= byteIn[TOP_W-1:0];
      end else begin
        cnt <= cnt + 1'b1;
        word[{cnt, 3'b000} +: 8] <= byteIn;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: serial byte loader into instruction memory.
// Ports: clk, rst, start, inData/inValid/inReady, memWen/memAddr/memData, procRst/done/err. Option: LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int INST_W = INST_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        inData,
  input  logic              inValid,
  output logic              inReady,
  output logic              memWen,
  output logic [ADDR_W-1:0] memAddr,
  output logic [INST_W-1:0] memData,
  output logic              procRst,
  output logic              done,
  output logic              err
);

  loaderState_e st, stNext;

  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] lastIdx;
  logic [ADDR_W-1:0] addrHold;
  logic [INST_W-1:0] dataHold;
  logic [INST_W-1:0] asmWord;
  logic [7:0]        lenLo;
  logic [15:0]       lenN;
  logic              lenBad;
  logic              accept;
  logic              startOk;
  logic              asmFull;
  logic              lastWrite;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chkXor;
`endif

  assign accept    = inValid && inReady;
  assign startOk   = start &&
    (st == IDLE || st == DONE || st == ERR);
  assign lenN      = {inData, lenLo};
  assign lenBad    = (lenN == 16'd0) ||
    ({1'b0, lenN} > (17'd1 << ADDR_W));
  assign lastWrite = (idx == lastIdx);

`ifdef LOADER_CHECKSUM_EN
  assign inReady = (st == LEN_LO) || (st == LEN_HI) ||
    (st == COLLECT) || (st == CHK);
`else
  assign inReady = (st == LEN_LO) || (st == LEN_HI) ||
    (st == COLLECT);
`endif

  // Address/data show live values in WRITE, else last write.
  assign memWen  = (st == WRITE);
  assign memAddr = memWen ? idx : addrHold;
  assign memData = memWen ? asmWord : dataHold;
  assign procRst = (st != DONE);
  assign done    = (st == DONE);
  assign err     = (st == ERR);

  inst_assembler #(
    .INST_W(INST_W)
  ) uAsm (
    .clk      (clk),
    .rst      (rst),
    .clear    (startOk),
    .byteValid(accept && st == COLLECT),
    .byteIn   (inData),
    .word     (asmWord),
    .full     (asmFull)
  );

  always_comb begin
    stNext = st;
    unique case (st)
      IDLE:    if (start) stNext = LEN_LO;
      LEN_LO:  if (accept) stNext = LEN_HI;
      LEN_HI:  if (accept) stNext = lenBad ? ERR : COLLECT;
      COLLECT: if (accept && asmFull) stNext = WRITE;
      WRITE: begin
        if (!lastWrite) stNext = COLLECT;
`ifdef LOADER_CHECKSUM_EN
        else stNext = CHK;
`else
        else stNext = DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) stNext = (inData == chkXor) ? DONE : ERR;
      end
`endif
      DONE:    if (start) stNext = LEN_LO;
      ERR:     if (start) stNext = LEN_LO;
      default: stNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      idx      <= '0;
      lastIdx  <= '0;
      addrHold <= '0;
      dataHold <= '0;
      lenLo    <= '0;
    end else begin
      st <= stNext;
      if (startOk) idx <= '0;
      if (st == LEN_LO && accept) lenLo <= inData;
      if (st == LEN_HI && accept)
        lastIdx <= ADDR_W'(lenN - 16'd1);
      if (st == WRITE) begin
        addrHold <= idx;
        dataHold <= asmWord;
        // Saturate at the last index so a full-depth load
        // never wraps back to zero.
        if (!lastWrite) idx <= idx + 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || startOk) chkXor <= '0;
    else if (st == COLLECT && accept) chkXor <= chkXor ^ inData;
  end
`endif

endmodule
